dram_cmd_sequencer: RTL and testbench

Issues DDR4 command-bus cycles for single read or write requests, using a closed-page policy. It sits directly downstream of the request/address-decode front end. The request enters, the block issues ACT, then RD or WR, then PRE, and enforces row/column timing. It also schedules periodic REFRESH and drives the dram_state_t and cmd_t encodings defined in dram_pkg. The block becomes active once the init sequencer asserts init_done.

---
 rtl/dram_cmd_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_dram_cmd_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dram_cmd_sequencer.sv
// rtl/dram_cmd_sequencer.sv - DDR4 closed-page command sequencer: ACT, RD/WR, PRE per request plus periodic REF
module dram_cmd_sequencer #(
  parameter int T_RCD   = 10,
  parameter int T_RL    = 11,
  parameter int T_WL    = 11,
  parameter int T_BURST = 10,
  parameter int T_RAS   = 10,
  parameter int T_RP    = 10,
  parameter int T_RFC   = 10,
  parameter int T_REFI  = 10
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        init_done,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_bg,
  input  logic [1:0]  req_ba,
  input  logic [14:0] req_row,
  input  logic [9:0]  req_col,
  output logic [4:0]  cmd_o,
  output logic [1:0]  bg_o,
  output logic [1:0]  ba_o,
  output logic [14:0] addr_o,
  output logic [4:0]  state_o,
  output logic        rd_data_valid,
  output logic        wr_data_en,
  output logic        done
);

  localparam logic [4:0] S_IDLE        = 5'd0;
  localparam logic [4:0] S_ACTIVATE    = 5'd1;
  localparam logic [4:0] S_ACTIVATING  = 5'd2;
  localparam logic [4:0] S_READ        = 5'd3;
  localparam logic [4:0] S_WRITE       = 5'd4;
  localparam logic [4:0] S_READING     = 5'd5;
  localparam logic [4:0] S_WRITING     = 5'd6;
  localparam logic [4:0] S_PRECHARGE   = 5'd7;
  localparam logic [4:0] S_PRECHARGING = 5'd8;
  localparam logic [4:0] S_REFRESH     = 5'd9;
  localparam logic [4:0] S_REFRESHING  = 5'd10;

  localparam logic [4:0] DESEL_CMD     = 5'b11000;
  localparam logic [4:0] READ_CMD      = 5'b01101;
  localparam logic [4:0] WRITE_CMD     = 5'b01100;
  localparam logic [4:0] PRECHARGE_CMD = 5'b01010;
  localparam logic [4:0] REFRESH_CMD   = 5'b01001;

  localparam int CW     = 16;
  localparam int DQ_MAX = ((T_RL > T_WL) ? T_RL : T_WL) + T_BURST;

  // Wait loads are "cycles in the waiting state minus one", so the next command lands exactly on its deadline.
  localparam logic [CW-1:0] C_ONE      = CW'(1);
  localparam logic [CW-1:0] C_RCD_W    = CW'(T_RCD - 2);
  localparam logic [CW-1:0] C_RD_W     = CW'(T_RL + T_BURST - 2);
  localparam logic [CW-1:0] C_WR_W     = CW'(T_WL + T_BURST - 2);
  localparam logic [CW-1:0] C_RP_W     = CW'(T_RP - 2);
  localparam logic [CW-1:0] C_RFC_W    = CW'(T_RFC - 2);
  localparam logic [CW-1:0] C_RAS      = CW'(T_RAS - 1);
  localparam logic [CW-1:0] C_REFI_MAX = CW'(T_REFI - 1);
  localparam logic [CW-1:0] C_DQ_MAX   = CW'(DQ_MAX);
  localparam logic [CW-1:0] C_RL       = CW'(T_RL);
  localparam logic [CW-1:0] C_RL_END   = CW'(T_RL + T_BURST);
  localparam logic [CW-1:0] C_WL       = CW'(T_WL);
  localparam logic [CW-1:0] C_WL_END   = CW'(T_WL + T_BURST);

  logic [4:0]    r_state;
  logic [4:0]    w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] r_ras_cnt;
  logic [CW-1:0] r_dq_cnt;
  logic [CW-1:0] r_refi_cnt;
  logic          r_ref_pending;
  logic          r_done;
  logic          r_write;
  logic [1:0]    r_bg;
  logic [1:0]    r_ba;
  logic [14:0]   r_row;
  logic [9:0]    r_col;
  logic          w_accept;
  logic          w_refi_wrap;
  logic          w_cnt_zero;

  assign req_ready   = init_done && (r_state == S_IDLE) && !r_ref_pending;
  assign w_accept    = req_valid && req_ready;
  assign w_refi_wrap = init_done && (r_refi_cnt == C_REFI_MAX);
  assign w_cnt_zero  = (r_cnt == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_cnt_zero ? '0 : r_cnt - C_ONE;
    case (r_state)
      S_IDLE: begin
        if (r_ref_pending)  w_state_nxt = S_REFRESH;
        else if (w_accept)  w_state_nxt = S_ACTIVATE;
      end
      S_ACTIVATE: begin
        w_state_nxt = S_ACTIVATING;
        w_cnt_nxt   = C_RCD_W;
      end
      S_ACTIVATING: begin
        if (w_cnt_zero) w_state_nxt = r_write ? S_WRITE : S_READ;
      end
      S_READ: begin
        w_state_nxt = S_READING;
        w_cnt_nxt   = C_RD_W;
      end
      S_WRITE: begin
        w_state_nxt = S_WRITING;
        w_cnt_nxt   = C_WR_W;
      end
      S_READING, S_WRITING: begin
        // PRE waits for both the burst to drain and tRAS to expire.
        if (w_cnt_zero && (r_ras_cnt <= C_ONE)) w_state_nxt = S_PRECHARGE;
      end
      S_PRECHARGE: begin
        w_state_nxt = S_PRECHARGING;
        w_cnt_nxt   = C_RP_W;
      end
      S_PRECHARGING: begin
        if (w_cnt_zero) w_state_nxt = S_IDLE;
      end
      S_REFRESH: begin
        w_state_nxt = S_REFRESHING;
        w_cnt_nxt   = C_RFC_W;
      end
      S_REFRESHING: begin
        if (w_cnt_zero) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_ras_cnt     <= '0;
      r_dq_cnt      <= '0;
      r_refi_cnt    <= '0;
      r_ref_pending <= 1'b0;
      r_done        <= 1'b0;
      r_write       <= 1'b0;
      r_bg          <= '0;
      r_ba          <= '0;
      r_row         <= '0;
      r_col         <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= (r_state == S_PRECHARGING) && w_cnt_zero;

      if (r_state == S_ACTIVATE)  r_ras_cnt <= C_RAS;
      else if (r_ras_cnt != '0)   r_ras_cnt <= r_ras_cnt - C_ONE;

      // r_dq_cnt counts cycles since the column command; the data windows are decoded from it.
      if ((r_state == S_READ) || (r_state == S_WRITE))   r_dq_cnt <= C_ONE;
      else if ((r_dq_cnt != '0) && (r_dq_cnt < C_DQ_MAX)) r_dq_cnt <= r_dq_cnt + C_ONE;
      else                                                r_dq_cnt <= '0;

      if (!init_done || w_refi_wrap) r_refi_cnt <= '0;
      else                           r_refi_cnt <= r_refi_cnt + C_ONE;

      if (w_refi_wrap)                                  r_ref_pending <= 1'b1;
      else if ((r_state == S_IDLE) && r_ref_pending)   r_ref_pending <= 1'b0;

      if (w_accept) begin
        r_write <= req_write;
        r_bg    <= req_bg;
        r_ba    <= req_ba;
        r_row   <= req_row;
        r_col   <= req_col;
      end
    end
  end

  always_comb begin
    cmd_o  = DESEL_CMD;
    bg_o   = '0;
    ba_o   = '0;
    addr_o = '0;
    case (r_state)
      S_ACTIVATE: begin
        cmd_o  = {4'b0000, r_row[14]};
        bg_o   = r_bg;
        ba_o   = r_ba;
        addr_o = r_row;
      end
      S_READ, S_WRITE: begin
        cmd_o  = (r_state == S_WRITE) ? WRITE_CMD : READ_CMD;
        bg_o   = r_bg;
        ba_o   = r_ba;
        addr_o = {5'b00000, r_col};
      end
      S_PRECHARGE: begin
        cmd_o = PRECHARGE_CMD;
        bg_o  = r_bg;
        ba_o  = r_ba;
      end
      S_REFRESH: cmd_o = REFRESH_CMD;
      default: ;
    endcase
  end

  assign state_o       = r_state;
  assign done          = r_done;
  assign rd_data_valid = !r_write && (r_dq_cnt >= C_RL) && (r_dq_cnt < C_RL_END);
  assign wr_data_en    = r_write && (r_dq_cnt >= C_WL) && (r_dq_cnt < C_WL_END);

endmodule

// File: tb/tb_dram_cmd_sequencer.sv
// tb/tb_dram_cmd_sequencer.sv - randomized bench for dram_cmd_sequencer against a cycle-timeline reference model
module tb_dram_cmd_sequencer;

  localparam int P_RCD = 10, P_RL = 11, P_WL = 6, P_BURST = 10;
  localparam int P_RAS = 28, P_RP = 10, P_RFC = 10, P_REFI = 150;
  localparam int MAXC  = 4096;

  localparam logic [4:0] DESEL = 5'b11000, RD = 5'b01101, WR = 5'b01100;
  localparam logic [4:0] PRE   = 5'b01010, REF = 5'b01001;

  logic        CLK, nRST, init_done, req_valid, req_ready, req_write;
  logic [1:0]  req_bg, req_ba, bg_o, ba_o;
  logic [14:0] req_row, addr_o;
  logic [9:0]  req_col;
  logic [4:0]  cmd_o, state_o;
  logic        rd_data_valid, wr_data_en, done;

  dram_cmd_sequencer #(
    .T_RCD(P_RCD), .T_RL(P_RL), .T_WL(P_WL), .T_BURST(P_BURST),
    .T_RAS(P_RAS), .T_RP(P_RP), .T_RFC(P_RFC), .T_REFI(P_REFI)
  ) dut (
    .CLK(CLK), .nRST(nRST), .init_done(init_done),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
    .cmd_o(cmd_o), .bg_o(bg_o), .ba_o(ba_o), .addr_o(addr_o), .state_o(state_o),
    .rd_data_valid(rd_data_valid), .wr_data_en(wr_data_en), .done(done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Expected command-bus and data-window activity, indexed by absolute cycle number.
  logic [4:0]  e_cmd  [MAXC];
  logic [1:0]  e_bg   [MAXC];
  logic [1:0]  e_ba   [MAXC];
  logic [14:0] e_addr [MAXC];
  bit          e_rdv  [MAXC];
  bit          e_wre  [MAXC];
  bit          e_done [MAXC];

  int cyc, free_at, run, n_checks, n_errs;
  bit pend;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic clear_from(input int n);
    for (int i = n; i < MAXC; i++) begin
      e_cmd[i] = DESEL; e_bg[i] = '0; e_ba[i] = '0; e_addr[i] = '0;
      e_rdv[i] = 0; e_wre[i] = 0; e_done[i] = 0;
    end
  endtask

  task automatic put_cmd(input int t, input logic [4:0] c, input logic [1:0] g,
                         input logic [1:0] b, input logic [14:0] a);
    if (t < MAXC) begin
      e_cmd[t] = c; e_bg[t] = g; e_ba[t] = b; e_addr[t] = a;
    end
  endtask

  // Closed-page request timeline: ACT, column command tRCD later, PRE after max(burst end, tRAS), idle after tRP.
  task automatic sched_req(input int c);
    int ta, tc, tp, xl;
    xl = req_write ? P_WL : P_RL;
    ta = c + 1;
    tc = ta + P_RCD;
    tp = tc + xl + P_BURST;
    if (ta + P_RAS > tp) tp = ta + P_RAS;
    put_cmd(ta, {4'b0000, req_row[14]}, req_bg, req_ba, req_row);
    put_cmd(tc, req_write ? WR : RD, req_bg, req_ba, {5'b00000, req_col});
    put_cmd(tp, PRE, req_bg, req_ba, 15'd0);
    for (int k = 0; k < P_BURST; k++) begin
      if (tc + xl + k < MAXC) begin
        if (req_write) e_wre[tc + xl + k] = 1;
        else           e_rdv[tc + xl + k] = 1;
      end
    end
    free_at = tp + P_RP;
    if (free_at < MAXC) e_done[free_at] = 1;
  endtask

  task automatic step();
    bit idle, exp_ready, wrap;
    @(negedge CLK);
    idle      = (cyc >= free_at);
    exp_ready = idle && init_done && !pend;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("idle",      32'(state_o == 5'd0), 32'(idle));
    chk("cmd",       32'(cmd_o),  32'(e_cmd[cyc]));
    chk("bg",        32'(bg_o),   32'(e_bg[cyc]));
    chk("ba",        32'(ba_o),   32'(e_ba[cyc]));
    chk("addr",      32'(addr_o), 32'(e_addr[cyc]));
    chk("rd_valid",  32'(rd_data_valid), 32'(e_rdv[cyc]));
    chk("wr_en",     32'(wr_data_en),    32'(e_wre[cyc]));
    chk("done",      32'(done),          32'(e_done[cyc]));
    if (idle && pend) begin
      put_cmd(cyc + 1, REF, 2'd0, 2'd0, 15'd0);
      free_at = cyc + 1 + P_RFC;
    end else if (exp_ready && req_valid) begin
      sched_req(cyc);
    end
    wrap = init_done && ((run % P_REFI) == P_REFI - 1);
    run  = init_done ? run + 1 : 0;
    pend = wrap || (pend && !(idle && pend));
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_req(input logic v, input logic w, input logic [14:0] row, input logic [9:0] col);
    req_valid = v; req_write = w; req_row = row; req_col = col;
    req_bg = 2'($urandom_range(0, 3)); req_ba = 2'($urandom_range(0, 3));
  endtask

  task automatic mid_reset();
    req_valid = 1'b0;
    #2;
    chk("rdv_before_rst", 32'(rd_data_valid), 32'(e_rdv[cyc]));
    nRST = 1'b0;
    #1;
    chk("rst_cmd",   32'(cmd_o), 32'(DESEL));
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_rdv",   32'(rd_data_valid), 32'd0);
    chk("rst_addr",  32'(addr_o), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    cyc++;
    clear_from(cyc);
    free_at = cyc; pend = 0; run = 0;
  endtask

  initial begin
    int low_left;
    n_checks = 0; n_errs = 0; cyc = 0; free_at = 0; run = 0; pend = 0;
    clear_from(0);
    nRST = 1'b1; init_done = 1'b0;
    set_req(1'b0, 1'b0, 15'd0, 10'd0);
    #1 nRST = 1'b0;
    #1;
    chk("reset_cmd",   32'(cmd_o), 32'(DESEL));
    chk("reset_state", 32'(state_o), 32'd0);
    chk("reset_addr",  32'({bg_o, ba_o, addr_o}), 32'd0);
    chk("reset_ready", 32'(req_ready), 32'd0);
    chk("reset_outs",  32'({rd_data_valid, wr_data_en, done}), 32'd0);
    @(posedge CLK);
    #1 nRST = 1'b1;

    // Not yet initialised: requests must be ignored and no refresh scheduled.
    set_req(1'b1, 1'b0, 15'h1234, 10'h3FF);
    steps(50);

    init_done = 1'b1;
    set_req(1'b1, 1'b0, 15'h4ABC, 10'h155);
    step();
    req_valid = 1'b0;
    steps(45);
    set_req(1'b1, 1'b1, 15'h0ABC, 10'h2AA);
    step();
    req_valid = 1'b0;
    steps(55);

    // Back-to-back: requests held valid across several completions.
    set_req(1'b1, 1'b0, 15'h7FFF, 10'h001);
    steps(130);

    // Reset during a read burst.
    while (cyc < free_at) step();
    set_req(1'b1, 1'b0, 15'h4ABC, 10'h155);
    if (pend) steps(P_RFC + 2);
    set_req(1'b1, 1'b0, 15'h4ABC, 10'h155);
    while (!(req_ready === 1'b1) && cyc < 2000) step();
    step();
    req_valid = 1'b0;
    steps(24);
    mid_reset();
    set_req(1'b1, 1'b0, 15'h2222, 10'h0F0);
    step();
    req_valid = 1'b0;
    steps(50);

    low_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (low_left > 0) begin
        low_left--;
        init_done = 1'b0;
      end else begin
        init_done = 1'b1;
        if ($urandom_range(0, 399) == 0) low_left = $urandom_range(1, 20);
      end
      set_req(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              15'($urandom), 10'($urandom));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
